// File: rtl/kt_pkg.sv
// Kitchen timer front-panel defaults: button count, debounce and auto-repeat timing,
// and the channel index assigned to each physical button.
package kt_pkg;

    localparam int KT_N_BTN      = 4;
    localparam int KT_DB_CNT_W   = 16;
    localparam int KT_RPT_DELAY  = 2**24;
    localparam int KT_RPT_PERIOD = 2**22;
    localparam int KT_RPT_W      = 25;

    localparam int BTN_START = 0;
    localparam int BTN_MIN   = 1;
    localparam int BTN_SEC   = 2;
    localparam int BTN_MODE  = 3;

endpackage

// File: rtl/pb_channel.sv
// One pushbutton channel: 2-FF synchroniser, mismatch-window debouncer, hold-to-repeat
// timer and a wrapping 8-bit press counter.
module pb_channel
    import kt_pkg::*;
#(
    parameter int CNT_W         = KT_DB_CNT_W,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = KT_RPT_DELAY,
    parameter int REPEAT_PERIOD = KT_RPT_PERIOD,
    parameter int RPT_W         = KT_RPT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_raw,
    input  logic       clr_cnt,
    output logic       pb_state,
    output logic       pb_down,
    output logic       pb_up,
    output logic       pb_repeat,
    output logic [7:0] press_cnt
);

    localparam logic             RELEASED_LVL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DB_ONE       = 1;
    localparam logic [RPT_W-1:0] RPT_ONE      = 1;
    localparam logic [RPT_W-1:0] DELAY_V      = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] PERIOD_V     = RPT_W'(REPEAT_PERIOD);

    logic             sync1, sync2;
    logic             s;
    logic [CNT_W-1:0] db_cnt;
    logic [RPT_W-1:0] rpt_tmr;
    logic [RPT_W-1:0] rpt_target;
    logic             rpt_armed;
    logic             mismatch;
    logic             flip;
    logic             rpt_hit;

    assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    // A release that qualifies this cycle suppresses any repeat that would also land here.
    always_comb begin
        mismatch   = (s != pb_state);
        flip       = mismatch && (&db_cnt);
        rpt_target = rpt_armed ? PERIOD_V : DELAY_V;
        rpt_hit    = 1'b0;
        if ((REPEAT_DELAY != 0) && pb_state && !flip)
            rpt_hit = ((rpt_tmr + RPT_ONE) == rpt_target);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= RELEASED_LVL;
            sync2     <= RELEASED_LVL;
            db_cnt    <= '0;
            pb_state  <= 1'b0;
            pb_down   <= 1'b0;
            pb_up     <= 1'b0;
            pb_repeat <= 1'b0;
            rpt_tmr   <= '0;
            rpt_armed <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            sync1 <= pb_raw;
            sync2 <= sync1;

            db_cnt <= (mismatch && !flip) ? (db_cnt + DB_ONE) : '0;
            if (flip)
                pb_state <= ~pb_state;

            pb_down   <= flip && !pb_state;
            pb_up     <= flip && pb_state;
            pb_repeat <= rpt_hit;

            // Timer restarts from zero on every press; first target is the delay, then the period.
            if (!pb_state || flip || (REPEAT_DELAY == 0)) begin
                rpt_tmr   <= '0;
                rpt_armed <= 1'b0;
            end else if (rpt_hit) begin
                rpt_tmr   <= '0;
                rpt_armed <= 1'b1;
            end else begin
                rpt_tmr <= rpt_tmr + RPT_ONE;
            end

            // Counter moves on the same edge that registers the pulse; a clear on that edge wins.
            if (clr_cnt)
                press_cnt <= 8'd0;
            else if ((flip && !pb_state) || rpt_hit)
                press_cnt <= press_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/multi_pb_debouncer.sv
// N-channel pushbutton conditioner for the kitchen timer panel; one independent
// pb_channel per button, the top only slices the buses.
module multi_pb_debouncer
    import kt_pkg::*;
#(
    parameter int N_CH          = KT_N_BTN,
    parameter int CNT_W         = KT_DB_CNT_W,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = KT_RPT_DELAY,
    parameter int REPEAT_PERIOD = KT_RPT_PERIOD,
    parameter int RPT_W         = KT_RPT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   pb_raw,
    input  logic [N_CH-1:0]   clr_cnt,
    output logic [N_CH-1:0]   pb_state,
    output logic [N_CH-1:0]   pb_down,
    output logic [N_CH-1:0]   pb_up,
    output logic [N_CH-1:0]   pb_repeat,
    output logic [8*N_CH-1:0] press_cnt
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pb_channel #(
            .CNT_W         (CNT_W),
            .ACTIVE_LOW    (ACTIVE_LOW),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .RPT_W         (RPT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .pb_raw    (pb_raw[i]),
            .clr_cnt   (clr_cnt[i]),
            .pb_state  (pb_state[i]),
            .pb_down   (pb_down[i]),
            .pb_up     (pb_up[i]),
            .pb_repeat (pb_repeat[i]),
            .press_cnt (press_cnt[8*i +: 8])
        );
    end

endmodule

// File: tb/tb_multi_pb_debouncer.sv
// Directed bench for multi_pb_debouncer with short timing: debounce window 8 cycles
// (10 cycles raw edge to pulse), first repeat 20 cycles after press, then every 5.
module tb_multi_pb_debouncer;
    import kt_pkg::*;

    localparam int N_CH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   pb_raw;
    logic [N_CH-1:0]   clr_cnt;
    logic [N_CH-1:0]   pb_state;
    logic [N_CH-1:0]   pb_down;
    logic [N_CH-1:0]   pb_up;
    logic [N_CH-1:0]   pb_repeat;
    logic [8*N_CH-1:0] press_cnt;

    int checks = 0;
    int errors = 0;

    multi_pb_debouncer #(
        .N_CH          (N_CH),
        .CNT_W         (3),
        .ACTIVE_LOW    (1),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5),
        .RPT_W         (25)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pb_raw    (pb_raw),
        .clr_cnt   (clr_cnt),
        .pb_state  (pb_state),
        .pb_down   (pb_down),
        .pb_up     (pb_up),
        .pb_repeat (pb_repeat),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full press/release on one channel, short enough that no repeat fires.
    task automatic press_release(input int ch);
        pb_raw[ch] = 1'b0;
        tick(10);
        pb_raw[ch] = 1'b1;
        tick(10);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        pb_raw  = 4'hF;
        clr_cnt = 4'h0;
        tick(3);
        rst = 1'b0;
        checks++;
        if ({pb_state, pb_down, pb_up, pb_repeat} !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %h, want 0000", {pb_state, pb_down, pb_up, pb_repeat});
        end
        checks++;
        if (press_cnt !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_cnt: got %h, want 00000000", press_cnt);
        end
        for (int k = 1; k <= 50; k++) begin
            tick(1);
            checks++;
            if ({pb_state, pb_down, pb_up, pb_repeat, press_cnt} !== 48'h0) begin
                errors++;
                $display("[TB] FAIL idle k=%0d: got %h, want 0", k, {pb_state, pb_down, pb_up, pb_repeat, press_cnt});
            end
        end
    endtask

    task automatic test_press();
        pb_raw[BTN_START] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            checks++;
            if (pb_down[0] !== (k == 10)) begin
                errors++;
                $display("[TB] FAIL press_down0 k=%0d: got %b, want %b", k, pb_down[0], (k == 10));
            end
        end
        checks++;
        if (pb_state[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL press_state0: got %b, want 1", pb_state[0]);
        end
        checks++;
        if (press_cnt[7:0] !== 8'd1) begin
            errors++;
            $display("[TB] FAIL press_cnt0: got %0d, want 1", press_cnt[7:0]);
        end
    endtask

    // Entered on the cycle pb_down[0] is visible; raw released 50 cycles later.
    task automatic test_repeat();
        logic exp_rpt;
        for (int k = 1; k <= 60; k++) begin
            tick(1);
            exp_rpt = (k >= 20) && (k <= 55) && (((k - 20) % 5) == 0);
            checks++;
            if (pb_repeat[0] !== exp_rpt) begin
                errors++;
                $display("[TB] FAIL repeat0 k=%0d: got %b, want %b", k, pb_repeat[0], exp_rpt);
            end
            checks++;
            if ({pb_down[0], pb_up[0], pb_state[0]} !== {1'b0, (k == 60), (k < 60)}) begin
                errors++;
                $display("[TB] FAIL hold0 k=%0d: got dn/up/st=%b, want %b", k,
                         {pb_down[0], pb_up[0], pb_state[0]}, {1'b0, (k == 60), (k < 60)});
            end
            if (k == 50)
                pb_raw[0] = 1'b1;
        end
        checks++;
        if (press_cnt[7:0] !== 8'd9) begin
            errors++;
            $display("[TB] FAIL repeat_cnt0: got %0d, want 9", press_cnt[7:0]);
        end
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            checks++;
            if ({pb_repeat[0], pb_up[0], pb_state[0]} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL after_release0 k=%0d: got %b, want 000", k, {pb_repeat[0], pb_up[0], pb_state[0]});
            end
        end
    endtask

    task automatic test_bounce();
        pb_raw[BTN_MIN] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            checks++;
            if (pb_down[1] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bounce_low k=%0d: got %b, want 0", k, pb_down[1]);
            end
        end
        pb_raw[1] = 1'b1;
        tick(1);
        pb_raw[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            checks++;
            if ({pb_down[1], pb_state[1]} !== {(k == 10), (k == 10)}) begin
                errors++;
                $display("[TB] FAIL bounce_down1 k=%0d: got dn/st=%b, want %b", k,
                         {pb_down[1], pb_state[1]}, {(k == 10), (k == 10)});
            end
        end
        pb_raw[1] = 1'b1;
        tick(10);
        checks++;
        if ({pb_up[1], press_cnt[15:8]} !== {1'b1, 8'd1}) begin
            errors++;
            $display("[TB] FAIL bounce_up1: got up=%b cnt=%0d, want up=1 cnt=1", pb_up[1], press_cnt[15:8]);
        end
    endtask

    task automatic test_wrap_clear();
        for (int p = 0; p < 255; p++)
            press_release(BTN_SEC);
        checks++;
        if (press_cnt[23:16] !== 8'd255) begin
            errors++;
            $display("[TB] FAIL cnt2_255: got %0d, want 255", press_cnt[23:16]);
        end
        press_release(BTN_SEC);
        checks++;
        if (press_cnt[23:16] !== 8'd0) begin
            errors++;
            $display("[TB] FAIL cnt2_wrap: got %0d, want 0", press_cnt[23:16]);
        end
        press_release(BTN_SEC);
        press_release(BTN_SEC);
        checks++;
        if (press_cnt[23:16] !== 8'd2) begin
            errors++;
            $display("[TB] FAIL cnt2_two: got %0d, want 2", press_cnt[23:16]);
        end
        pb_raw[2] = 1'b0;
        tick(9);
        clr_cnt[2] = 1'b1;
        tick(1);
        clr_cnt[2] = 1'b0;
        checks++;
        if ({pb_down[2], press_cnt[23:16]} !== {1'b1, 8'd0}) begin
            errors++;
            $display("[TB] FAIL clr_vs_down2: got dn=%b cnt=%0d, want dn=1 cnt=0", pb_down[2], press_cnt[23:16]);
        end
        tick(1);
        checks++;
        if (press_cnt[23:16] !== 8'd0) begin
            errors++;
            $display("[TB] FAIL clr_hold2: got %0d, want 0", press_cnt[23:16]);
        end
        pb_raw[2] = 1'b1;
        tick(12);
    endtask

    task automatic test_reset_mid_hold();
        pb_raw[BTN_MODE] = 1'b0;
        tick(10);
        tick(27);
        checks++;
        if ({pb_state[3], press_cnt[31:24]} !== {1'b1, 8'd3}) begin
            errors++;
            $display("[TB] FAIL hold3_cnt: got st=%b cnt=%0d, want st=1 cnt=3", pb_state[3], press_cnt[31:24]);
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if ({pb_state, pb_down, pb_up, pb_repeat, press_cnt} !== 48'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %h, want 0", {pb_state, pb_down, pb_up, pb_repeat, press_cnt});
        end
        tick(1);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            checks++;
            if ({pb_down[3], pb_state[3]} !== {(k == 10), (k == 10)}) begin
                errors++;
                $display("[TB] FAIL requal3 k=%0d: got dn/st=%b, want %b", k,
                         {pb_down[3], pb_state[3]}, {(k == 10), (k == 10)});
            end
        end
        checks++;
        if (press_cnt !== 32'h0100_0000) begin
            errors++;
            $display("[TB] FAIL requal_cnt: got %h, want 01000000", press_cnt);
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_press();
        test_repeat();
        test_bounce();
        test_wrap_clear();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
